// File: rtl/game_pkg.sv
// Shared definitions for the Flappy Bird game-flow logic: phase encoding,
// BCD score limits, bird/pipe geometry and a BCD magnitude compare helper.
package game_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT   = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_DYING     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_e;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Geometry shared with the physics and pipe renderer blocks
    localparam int BIRD_X = 200;
    localparam int BIRD_W = 24;
    localparam int BIRD_H = 24;

    // True when BCD value a is strictly greater than b, deciding on the
    // most significant digit that differs.
    function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter: synchronous clear, increment enable, carry
// ripples across all digits in one cycle and the count holds at 9999.
import game_pkg::*;

module bcd_counter4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] value_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        carry;

    // Next count: clear has priority, increment saturates at BCD_MAX
    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b0;
        if (clr_i) begin
            cnt_d = 16'h0000;
        end else if (inc_i && (cnt_q != BCD_MAX)) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] == 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= 16'h0000;
        else        cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: ATTRACT -> PLAYING -> DYING -> GAME_OVER, flap
// gating, restart pulse, BCD score and game-over blink.
// Optional feature macro: HIGH_SCORE_EN (keeps a best score across runs).
import game_pkg::*;

module game_sequencer #(
    parameter int DEATH_FRAMES = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        button,
    input  logic        bird_alive,
    input  logic        pipe_passed,
    output logic        game_restart,
    output logic        flap,
    output logic        pipe_enable,
    output logic [1:0]  state,
    output logic        blink,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    game_state_e state_q, state_d;
    logic        button_q;
    logic [7:0]  death_q, death_d;
    logic [7:0]  blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        restart_q, restart_d;
    logic        flap_q, flap_d;
    logic        press;
    logic        start;
    logic        score_inc;
    logic [15:0] score_w;

    assign press     = button & ~button_q;
    assign score_inc = (state_q == ST_PLAYING) & bird_alive & pipe_passed;

    // Next-state, timers and one-cycle pulses; a start (press in ATTRACT or
    // GAME_OVER) overrides everything to begin a fresh run
    always_comb begin
        state_d     = state_q;
        death_d     = death_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        restart_d   = 1'b0;
        flap_d      = 1'b0;
        start       = 1'b0;
        case (state_q)
            ST_ATTRACT: begin
                if (press) start = 1'b1;
            end
            ST_PLAYING: begin
                flap_d = press;
                if (!bird_alive) begin
                    state_d = ST_DYING;
                    death_d = 8'(DEATH_FRAMES);
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (death_q == 8'd1) begin
                        state_d     = ST_GAME_OVER;
                        blink_d     = 1'b0;
                        blink_cnt_d = 8'd0;
                    end else begin
                        death_d = death_q - 8'd1;
                    end
                end
            end
            ST_GAME_OVER: begin
                if (press) begin
                    start = 1'b1;
                end else if (frame_tick) begin
                    if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d = 8'd0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_ATTRACT;
        endcase
        if (start) begin
            state_d     = ST_PLAYING;
            restart_d   = 1'b1;
            flap_d      = 1'b1;
            blink_d     = 1'b0;
            blink_cnt_d = 8'd0;
        end
    end

    // State, timers, button history and output pulse registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_ATTRACT;
            button_q    <= 1'b0;
            death_q     <= 8'd0;
            blink_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
            restart_q   <= 1'b0;
            flap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            button_q    <= button;
            death_q     <= death_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            restart_q   <= restart_d;
            flap_q      <= flap_d;
        end
    end

    bcd_counter4 u_score (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (start),
        .inc_i   (score_inc),
        .value_o (score_w)
    );

`ifdef HIGH_SCORE_EN
    logic [15:0] high_q;
    logic        hs_update;

    // Best score is judged once per run, as the death animation ends
    assign hs_update = (state_q == ST_DYING) & frame_tick & (death_q == 8'd1);

    // High-score register; cleared only by reset, survives restarts
    always_ff @(posedge clk) begin
        if (!reset)                                high_q <= 16'h0000;
        else if (hs_update && bcd_gt(score_w, high_q)) high_q <= score_w;
    end

    assign high_score = high_q;
`else
    assign high_score = 16'h0000;
`endif

    assign game_restart = restart_q;
    assign flap         = flap_q;
    assign pipe_enable  = (state_q == ST_PLAYING);
    assign state        = state_q;
    assign blink        = blink_q;
    assign score        = score_w;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus drives inputs on the falling
// edge and pushes the reference model's expected outputs; a monitor pops
// and compares one entry after every rising edge.
module tb_game_sequencer;

    localparam int DEATH = 60;
    localparam int BLINK = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        button = 1'b0;
    logic        bird_alive = 1'b1;
    logic        pipe_passed = 1'b0;
    logic        game_restart, flap, pipe_enable, blink;
    logic [1:0]  state;
    logic [15:0] score, high_score;

    game_sequencer #(.DEATH_FRAMES(DEATH), .BLINK_FRAMES(BLINK)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .button       (button),
        .bird_alive   (bird_alive),
        .pipe_passed  (pipe_passed),
        .game_restart (game_restart),
        .flap         (flap),
        .pipe_enable  (pipe_enable),
        .state        (state),
        .blink        (blink),
        .score        (score),
        .high_score   (high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic        rs, fl, pe, bl;
        logic [15:0] sc, hs;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: phase number, integer scores and tick counts
    int m_phase = 0, m_score = 0, m_hs = 0, m_die = 0, m_go = 0;
    bit m_btn = 0, m_rs = 0, m_fl = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic step(input bit rst, input bit btn, input bit alive,
                        input bit passed, input bit tick);
        bit   pr;
        exp_t e;
        @(negedge clk);
        reset = rst; button = btn; bird_alive = alive;
        pipe_passed = passed; frame_tick = tick;
        if (!rst) begin
            m_phase = 0; m_score = 0; m_hs = 0; m_die = 0; m_go = 0;
            m_btn = 0; m_rs = 0; m_fl = 0;
        end else begin
            pr = btn && !m_btn;
            m_btn = btn; m_rs = 0; m_fl = 0;
            case (m_phase)
                0: if (pr) begin m_phase = 1; m_score = 0; m_rs = 1; m_fl = 1; end
                1: begin
                    m_fl = pr;
                    if (!alive) begin m_phase = 2; m_die = 0; end
                    else if (passed && m_score < 9999) m_score++;
                end
                2: if (tick) begin
                    m_die++;
                    if (m_die == DEATH) begin
                        m_phase = 3; m_go = 0;
`ifdef HIGH_SCORE_EN
                        if (m_score > m_hs) m_hs = m_score;
`endif
                    end
                end
                default: begin
                    if (pr) begin m_phase = 1; m_score = 0; m_rs = 1; m_fl = 1; m_go = 0; end
                    else if (tick) m_go++;
                end
            endcase
        end
        e.st = 2'(m_phase);
        e.rs = m_rs;
        e.fl = m_fl;
        e.pe = (m_phase == 1);
        e.bl = (m_phase == 3) && (((m_go / BLINK) % 2) == 1);
        e.sc = to_bcd(m_score);
        e.hs = to_bcd(m_hs);
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 1, 0, 0);
    endtask

    task automatic press_release();
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
    endtask

    task automatic passes(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 1, 1, 0);
            step(1, 0, 1, 0, $urandom_range(0, 1));
        end
    endtask

    // Collide (with a simultaneous pipe pass), then mash the button and
    // tick frames until the model reaches GAME_OVER
    task automatic die_and_go();
        int guard;
        step(1, 0, 0, 1, 0);
        guard = 0;
        while (m_phase != 3 && guard < 2000) begin
            step(1, $urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 1));
            guard++;
        end
        step(1, 0, 1, 0, 0);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if ({state, game_restart, flap, pipe_enable, blink, score, high_score} !==
                    {e.st, e.rs, e.fl, e.pe, e.bl, e.sc, e.hs}) begin
                    failures++;
                    $display("FAIL outputs t=%0t got st=%0d rs=%b fl=%b pe=%b bl=%b sc=%h hs=%h exp st=%0d rs=%b fl=%b pe=%b bl=%b sc=%h hs=%h",
                             $time, state, game_restart, flap, pipe_enable, blink, score, high_score,
                             e.st, e.rs, e.fl, e.pe, e.bl, e.sc, e.hs);
                end
            end
        end
    end

    initial begin
        bit alive_l, btn_l;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        idle(3);
        press_release();                         // ATTRACT -> PLAYING
        passes(10);                              // score 0010
        for (int i = 0; i < 100; i++) step(1, 1, 1, 0, i[0]);  // one flap only
        step(1, 0, 1, 0, 0);
        press_release();                         // second flap
        for (int i = 0; i < 10010; i++) step(1, 0, 1, 1, $urandom_range(0, 1));  // 0999->1000, hold 9999
        die_and_go();
        for (int i = 0; i < 70; i++) step(1, 0, 1, 0, 1);      // blink at 30 and 60 ticks
        press_release();                         // restart from GAME_OVER
        passes(5);
        die_and_go();                            // score stays 5
        idle(5);
        step(0, 0, 1, 0, 0);                     // reset clears high score
        step(0, 0, 1, 0, 0);
        press_release();
        passes(12);
        die_and_go();
        press_release();
        passes(7);
        die_and_go();                            // high score keeps 12
        idle(3);
        alive_l = 1; btn_l = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) alive_l = ~alive_l;
            if ($urandom_range(0, 5) == 0) btn_l = ~btn_l;
            step($urandom_range(0, 699) != 0, btn_l, alive_l,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
        end
        press_release();
        passes(3);
        step(0, 1, 1, 1, 1);                     // reset mid-run
        idle(3);
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game-flow controller for the Flappy Bird VGA design.
- Sequences the bird physics and pipe renderer through attract, play, death and game-over phases.
- Gates the flap button into the physics block and keeps a 4-digit BCD score, with an optional high score.
- Sits beside the pixel/colour logic. Consumes per-frame and per-event pulses; drives enables, restart and score outputs.

Parameters:
- DEATH_FRAMES, 60, frames spent in DYING before GAME_OVER is entered (1..255).
- BLINK_FRAMES, 30, frames per half-period of the game-over blink output (1..255).

Ports:
- clk  in  1  system clock (pixel-domain clock used by all VGA logic)
- reset  in  1  synchronous, active-low reset: reset==0 at a clk edge resets the block
- frame_tick  in  1  one-cycle pulse once per video frame (start of vblank)
- button  in  1  debounced flap button level, active-high
- bird_alive  in  1  level from the physics block; 0 = bird has died
- pipe_passed  in  1  one-cycle pulse when a pipe's trailing edge passes the bird column
- game_restart  out  1  one-cycle pulse; clears physics and pipes for a new run
- flap  out  1  one-cycle flap pulse to the physics block
- pipe_enable  out  1  pipes scroll while 1
- state  out  2  current phase: 0 ATTRACT, 1 PLAYING, 2 DYING, 3 GAME_OVER
- blink  out  1  game-over text blink
- score  out  16  4-digit BCD score, digit 3 in [15:12]
- high_score  out  16  4-digit BCD best score (only when the feature is enabled, else tied 0)

Behaviour:
- Reset (reset==0 at clk edge): state=ATTRACT, score=0, blink=0, game_restart=0, flap=0, timers=0, button history=0. high_score=0 on reset only; it survives restarts.
- Press detection: button registered once; press = button & ~button_q. One press per rising edge; a held button gives no further presses.
- ATTRACT:
  - pipe_enable=0.
  - On press: next cycle state=PLAYING, score=0, game_restart=1 for one cycle, flap=1 in that same cycle (the first press also flaps).
- PLAYING:
  - pipe_enable=1; flap = press (registered, one-cycle latency from the button edge).
  - pipe_passed=1 with bird_alive=1: score += 1 in BCD, with carry ripple across 4 digits in one cycle. Saturates at 9999 with no wrap.
  - bird_alive=0: next state=DYING, death timer loaded with DEATH_FRAMES. If pipe_passed arrives in the same cycle, collision wins and score is not incremented.
- DYING:
  - pipe_enable=0; presses ignored and flap=0.
  - Timer decrements on each frame_tick; when it is 1 and frame_tick arrives, state=GAME_OVER.
  - HIGH_SCORE_EN compare/update happens on the DYING->GAME_OVER transition.
- GAME_OVER:
  - pipe_enable=0.
  - Blink timer counts frame_ticks; blink toggles every BLINK_FRAMES frames. blink is 0 on entry.
  - On press: same actions as ATTRACT press (restart pulse, flap, score cleared, state=PLAYING), blink forced to 0.
- game_restart and flap are never high outside their one-cycle pulses. game_restart is high only on ATTRACT/GAME_OVER -> PLAYING.
- reset asserted mid-run: all of the above reset values apply on the next edge regardless of state. Pulses in flight are dropped.
- frame_tick outside DYING/GAME_OVER has no effect on timers.
- All outputs registered; no combinational path from input to output.

Optional Feature:
- Macro HIGH_SCORE_EN.
- Defined:
  - On DYING->GAME_OVER, if score > high_score (BCD compare, digit-wise from MSD), high_score <= score.
  - Output high_score valid.
- Undefined: no high-score register; high_score output constant 16'h0000.

Decomposition:
- Package game_pkg:
  - state encoding constants: ST_ATTRACT=2'd0, ST_PLAYING=2'd1, ST_DYING=2'd2, ST_GAME_OVER=2'd3.
  - BCD_MAX=16'h9999.
  - shared bird/pipe geometry constants (BIRD_X=200, sprite 24x24).
- Sub-module bcd_counter4: synchronous clear, increment enable, saturate at 9999, value out.
- FSM, timers and press detection stay in game_sequencer.

Test Plan:
- Reset, then a press in ATTRACT -> state=1 after 1 cycle; game_restart and flap each high exactly 1 cycle; score=16'h0000; pipe_enable=1.
- In PLAYING, 10 pipe_passed pulses -> score=16'h0010. From preset 16'h0999 plus one pulse -> 16'h1000. At 16'h9999 plus one pulse -> stays 16'h9999.
- Hold button high for 100 cycles in PLAYING -> exactly one flap pulse. Release and press again -> second pulse.
- Drop bird_alive with pipe_passed in the same cycle at score 5 -> score stays 5, state=2. After 60 frame_ticks state=3. Presses during DYING produce no flap or restart.
- In GAME_OVER, blink toggles after 30 and 60 frame_ticks. A press -> state=1, score=0, blink=0, one restart pulse.
- With HIGH_SCORE_EN: run 1 scores 12, run 2 scores 7 -> high_score=16'h0012. Assert reset -> high_score=0. Without the macro -> high_score always 0.
